seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Parametrised N-digit multiplexed seven-segment driver; successor to the two-digit alternating segment driver.
- Time-multiplexes NUM_DIGITS segment patterns onto one shared segment bus and drives a one-hot digit-select (anode) vector.
- Adds per-digit enable with skip, frame-synchronous double-buffered data, and a frame-done strobe.
- Sits between display-formatting logic (BCD-to-segment encoders) and the board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..16).
- SEG_W, 7, segment bits per digit.
- DIV, 7500, refresh divider; one digit slot lasts DIV+1 clk cycles.
- CNT_W, 13, divider counter width; must satisfy 2**CNT_W > DIV.
- IDX_W, $clog2(NUM_DIGITS), digit index width (localparam).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- digits_in  input  NUM_DIGITS*SEG_W  segment patterns; digit k occupies bits [k*SEG_W +: SEG_W].
- load  input  1  capture digits_in into the pending buffer this cycle.
- digit_en  input  NUM_DIGITS  per-digit enable; disabled digits are skipped; sampled live.
- segment  output  SEG_W  registered segment pattern of the displayed digit.
- anode  output  NUM_DIGITS  registered one-hot digit select, active-high; all-zero means blank.
- frame_done  output  1  one-cycle pulse when the scan wraps; marks the buffer swap.
- brightness  input  4  only present with SEVEN_SEG_BRIGHTNESS_EN.

Behaviour:
- Reset (synchronous, active-high):
  - Takes priority over every other input.
  - Clears cnt, idx, the started flag, the pending buffer, the active buffer, segment, anode and frame_done.
  - Asserting rst mid-scan blanks the display on the next edge.
- Divider:
  - cnt counts 0..DIV, then wraps to 0. The cycle where cnt==DIV is a tick.
  - First tick occurs DIV+1 cycles after rst deasserts.
- Load:
  - When load=1 and this is not a swap cycle, pending <= digits_in.
- Tick, next-digit selection:
  - If started=0, search begins at digit 0 inclusive.
  - Otherwise search begins at idx+1 modulo NUM_DIGITS and wraps, including idx itself last.
  - The first digit with digit_en=1 becomes new idx. Then anode <= onehot(new idx), segment <= active[new idx], and started <= 1.
- Wrap / frame_done:
  - A wrap occurs when new idx <= old idx or started was 0.
  - Single-enabled-digit case: wrap occurs on every tick.
  - On a wrap, frame_done pulses in the same edge and active <= pending. The displayed segment for that tick already uses the new active contents.
- load on a swap cycle:
  - active receives the pre-cycle pending value; digits_in lands in pending and is shown next frame.
- All digits disabled at a tick:
  - segment <= 0, anode <= 0, idx unchanged, started <= 0.
  - frame_done pulses and the swap occurs.
- digit_en changes between ticks:
  - No effect on outputs until the next tick.
- Outputs:
  - All outputs are registered; no combinational path from inputs to outputs.
  - segment and anode are held constant between ticks, except brightness gating.

Optional Feature:
- Macro: SEVEN_SEG_BRIGHTNESS_EN.
- With the macro:
  - Adds the 4-bit brightness input and a free-running 4-bit pwm counter, reset to 0.
  - Output anode = anode_reg when pwm <= brightness, else all-zero.
  - brightness=15 is full-on; brightness=0 is a 1/16 duty.
  - segment is not gated.
  - The gating register is updated every clk, so anode stays registered.
- Without the macro:
  - No brightness port and no pwm counter.
  - anode equals the internal selection register.

Decomposition:
- Shared package seven_seg_pkg holds:
  - constants SEG_W_DEFAULT=7 and DIV_DEFAULT=7500;
  - the seg_t typedef (logic [6:0]);
  - a blank constant SEG_BLANK='0.
- One natural sub-module, seven_seg_next_sel: combinational round-robin search (start index, enable mask) -> {found, next_idx, wrapped}.
- The divider, buffers and output registers stay in the top module.

Test Plan:
All scenarios use NUM_DIGITS=4, DIV=3.
- Reset then idle, all digit_en=1, load digits 0x01,0x02,0x04,0x08 at cycle 1:
  - anode=0001 at cycle 4;
  - segment=0x01 and frame_done=1 at that same edge.
- Continue scanning:
  - anode sequence 0001, 0010, 0100, 1000, 0001 on every 4th cycle;
  - frame_done only on the 0001 ticks.
- digit_en=1010:
  - anode alternates 0010 and 1000;
  - frame_done pulses on each 0010 tick.
- digit_en=0000 at a tick: segment=0, anode=0, frame_done=1. Re-enable 0100: next tick anode=0100 with frame_done=1.
- load new data mid-frame (anode=0010):
  - displayed digits unchanged until the next wrap;
  - load asserted exactly on the wrap cycle is shown one frame later.
- rst asserted mid-scan: next edge segment=0, anode=0. With SEVEN_SEG_BRIGHTNESS_EN and brightness=3, anode is high 4 of every 16 cycles.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and defaults for the multiplexed seven-segment scanner.
package seven_seg_pkg;

    localparam int SEG_W_DEFAULT = 7;
    localparam int DIV_DEFAULT   = 7500;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = '0;

endpackage

// File: rtl/seven_seg_next_sel.sv
// Round-robin search for the next enabled digit after the current one.
module seven_seg_next_sel
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic [IDX_W-1:0]      idx,
    input  logic                  started,
    input  logic [NUM_DIGITS-1:0] en,
    output logic                  found,
    output logic [IDX_W-1:0]      next_idx,
    output logic                  wrapped
);

    always_comb begin
        int base;
        int c;
        found    = 1'b0;
        next_idx = idx;
        base     = started ? int'(idx) + 1 : 0;
        c        = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            c = (base + i) % NUM_DIGITS;
            if (!found && en[c]) begin
                found    = 1'b1;
                next_idx = IDX_W'(c);
            end
        end
        // With nothing found next_idx stays at idx, which also reads as a wrap
        wrapped = !started || (next_idx <= idx);
    end

endmodule

// File: rtl/seven_seg_scan.sv
// N-digit multiplexed seven-segment driver with double-buffered data.
// Optional anode PWM dimming under SEVEN_SEG_BRIGHTNESS_EN.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = SEG_W_DEFAULT,
    parameter int DIV        = DIV_DEFAULT,
    parameter int CNT_W      = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_DIGITS*SEG_W-1:0] digits_in,
    input  logic                        load,
    input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    input  logic [3:0]                  brightness,
`endif
    output logic [SEG_W-1:0]            segment,
    output logic [NUM_DIGITS-1:0]       anode,
    output logic                        frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]            cnt;
    logic [IDX_W-1:0]            idx;
    logic                        started;
    logic [NUM_DIGITS*SEG_W-1:0] pending;
    logic [NUM_DIGITS*SEG_W-1:0] active;
    logic [NUM_DIGITS*SEG_W-1:0] src;
    logic [NUM_DIGITS-1:0]       sel;
    logic [NUM_DIGITS-1:0]       sel_d;
    logic                        tick;
    logic                        found;
    logic                        wrapped;
    logic                        swap;
    logic [IDX_W-1:0]            nidx;

    seven_seg_next_sel #(
        .NUM_DIGITS (NUM_DIGITS),
        .IDX_W      (IDX_W)
    ) u_next_sel (
        .idx      (idx),
        .started  (started),
        .en       (digit_en),
        .found    (found),
        .next_idx (nidx),
        .wrapped  (wrapped)
    );

    assign tick = (cnt == CNT_W'(DIV));
    assign swap = tick && (!found || wrapped);
    // The digit shown on a wrap tick already comes from the freshly swapped buffer
    assign src  = swap ? pending : active;

    always_comb begin
        sel_d = sel;
        if (tick) begin
            sel_d = found ? (NUM_DIGITS'(1) << nidx) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            started    <= 1'b0;
            pending    <= '0;
            active     <= '0;
            sel        <= '0;
            segment    <= SEG_W'(SEG_BLANK);
            frame_done <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            frame_done <= swap;
            sel        <= sel_d;
            if (swap) begin
                active <= pending;
            end
            if (load) begin
                pending <= digits_in;
            end
            if (tick) begin
                if (found) begin
                    idx     <= nidx;
                    started <= 1'b1;
                    segment <= src[int'(nidx)*SEG_W +: SEG_W];
                end else begin
                    started <= 1'b0;
                    segment <= SEG_W'(SEG_BLANK);
                end
            end
        end
    end

`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0] pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm   <= '0;
            anode <= '0;
        end else begin
            pwm   <= pwm + 4'd1;
            anode <= (pwm <= brightness) ? sel_d : '0;
        end
    end
`else
    assign anode = sel;
`endif

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed table-driven bench for seven_seg_scan (4 digits, DIV=3).
module tb_seven_seg_scan;

    logic        clk;
    logic        rst;
    logic [27:0] digits_in;
    logic        load;
    logic [3:0]  digit_en;
    logic [6:0]  segment;
    logic [3:0]  anode;
    logic        frame_done;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0]  brightness;
`endif

    seven_seg_scan #(
        .NUM_DIGITS (4),
        .SEG_W      (7),
        .DIV        (3),
        .CNT_W      (13)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .load       (load),
        .digit_en   (digit_en),
`ifdef SEVEN_SEG_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .segment    (segment),
        .anode      (anode),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        int          ld_pos;
        logic [27:0] data;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fd;
    } vec_t;

    localparam logic [27:0] D1 = {7'h08, 7'h04, 7'h02, 7'h01};
    localparam logic [27:0] D2 = {7'h70, 7'h60, 7'h50, 7'h40};
    localparam logic [27:0] D3 = {7'h0F, 7'h0E, 7'h0D, 7'h0C};

    vec_t       tbl[26];
    int         passed = 0;
    int         total  = 0;
    logic [3:0] prev_an;
    logic [6:0] prev_seg;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Four edges ending on a tick; load is raised only before edge ld_pos
    task automatic run_slot(input int n, input vec_t v);
        digit_en = v.en;
        for (int e = 1; e <= 4; e++) begin
            load      = (v.ld_pos == e);
            digits_in = v.data;
            step();
            load = 1'b0;
            if (e == 2) begin
                chk($sformatf("row%0d hold anode", n), 32'(anode), 32'(prev_an));
                chk($sformatf("row%0d hold seg", n), 32'(segment), 32'(prev_seg));
                chk($sformatf("row%0d fd low", n), 32'(frame_done), 32'd0);
            end
        end
        chk($sformatf("row%0d anode", n), 32'(anode), 32'(v.an));
        chk($sformatf("row%0d segment", n), 32'(segment), 32'(v.seg));
        chk($sformatf("row%0d frame_done", n), 32'(frame_done), 32'(v.fd));
        prev_an  = v.an;
        prev_seg = v.seg;
    endtask

    initial begin
        int hi;
        tbl[0]  = '{4'b1111, 1, D1, 4'b0001, 7'h01, 1'b1};
        tbl[1]  = '{4'b1111, 0, D1, 4'b0010, 7'h02, 1'b0};
        tbl[2]  = '{4'b1111, 0, D1, 4'b0100, 7'h04, 1'b0};
        tbl[3]  = '{4'b1111, 0, D1, 4'b1000, 7'h08, 1'b0};
        tbl[4]  = '{4'b1111, 0, D1, 4'b0001, 7'h01, 1'b1};
        tbl[5]  = '{4'b1010, 0, D1, 4'b0010, 7'h02, 1'b0};
        tbl[6]  = '{4'b1010, 0, D1, 4'b1000, 7'h08, 1'b0};
        tbl[7]  = '{4'b1010, 0, D1, 4'b0010, 7'h02, 1'b1};
        tbl[8]  = '{4'b1010, 0, D1, 4'b1000, 7'h08, 1'b0};
        tbl[9]  = '{4'b0000, 0, D1, 4'b0000, 7'h00, 1'b1};
        tbl[10] = '{4'b0100, 0, D1, 4'b0100, 7'h04, 1'b1};
        tbl[11] = '{4'b0100, 0, D1, 4'b0100, 7'h04, 1'b1};
        tbl[12] = '{4'b1111, 0, D1, 4'b1000, 7'h08, 1'b0};
        tbl[13] = '{4'b1111, 0, D1, 4'b0001, 7'h01, 1'b1};
        tbl[14] = '{4'b1111, 1, D2, 4'b0010, 7'h02, 1'b0};
        tbl[15] = '{4'b1111, 0, D2, 4'b0100, 7'h04, 1'b0};
        tbl[16] = '{4'b1111, 0, D2, 4'b1000, 7'h08, 1'b0};
        tbl[17] = '{4'b1111, 0, D2, 4'b0001, 7'h40, 1'b1};
        tbl[18] = '{4'b1111, 0, D2, 4'b0010, 7'h50, 1'b0};
        tbl[19] = '{4'b1111, 0, D2, 4'b0100, 7'h60, 1'b0};
        tbl[20] = '{4'b1111, 0, D2, 4'b1000, 7'h70, 1'b0};
        tbl[21] = '{4'b1111, 4, D3, 4'b0001, 7'h40, 1'b1};
        tbl[22] = '{4'b1111, 0, D3, 4'b0010, 7'h50, 1'b0};
        tbl[23] = '{4'b1111, 0, D3, 4'b0100, 7'h60, 1'b0};
        tbl[24] = '{4'b1111, 0, D3, 4'b1000, 7'h70, 1'b0};
        tbl[25] = '{4'b1111, 0, D3, 4'b0001, 7'h0C, 1'b1};

        rst       = 1'b1;
        load      = 1'b0;
        digits_in = '0;
        digit_en  = 4'b1111;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
        brightness = 4'd15;
`endif
        step();
        step();
        rst = 1'b0;
        chk("reset anode", 32'(anode), 32'd0);
        chk("reset segment", 32'(segment), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        prev_an  = 4'b0000;
        prev_seg = 7'h00;

        for (int i = 0; i < 26; i++) run_slot(i, tbl[i]);

        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst anode", 32'(anode), 32'd0);
        chk("midrst segment", 32'(segment), 32'd0);
        chk("midrst frame_done", 32'(frame_done), 32'd0);
        step();
        step();
        step();
        chk("postrst pre-tick anode", 32'(anode), 32'd0);
        step();
        chk("postrst anode", 32'(anode), 32'b0001);
        chk("postrst segment", 32'(segment), 32'd0);
        chk("postrst frame_done", 32'(frame_done), 32'd1);

`ifdef SEVEN_SEG_BRIGHTNESS_EN
        brightness = 4'd3;
        step();
        step();
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (anode != 4'b0000) hi++;
        end
        chk("pwm duty", 32'(hi), 32'd4);
`else
        hi = 0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
